// File: rtl/step_button_pkg.sv
// Shared types and 50 MHz board defaults for the step button conditioner.
// Optional auto-repeat is enabled with STEP_BUTTON_AUTO_REPEAT_EN.
package step_button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce, 0.5 s first repeat, 0.2 s repeat period at 50 MHz
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_button_debounce_if.sv
// Button-side signal bundle: raw pad in, conditioned step pulse and level out.
interface step_button_debounce_if;
  logic btn_raw;
  logic step_pulse;
  logic btn_level;

  modport master (output btn_raw, input step_pulse, input btn_level);
  modport slave  (input btn_raw, output step_pulse, output btn_level);
endinterface

// File: rtl/btn_synchronizer.sv
// Multi-flop synchroniser bringing the asynchronous button pad into clk.
module btn_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/step_button_debounce.sv
// Push-button conditioner: synchronise, debounce, emit one step pulse per press.
// Define STEP_BUTTON_AUTO_REPEAT_EN to add hold-to-repeat pulses.
module step_button_debounce
  import step_button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                   clk,
  input logic                   reset,
  step_button_debounce_if.slave btn
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_cfg_err
    $error("step_button_debounce: invalid timing parameters");
  end

  logic             s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

`ifdef STEP_BUTTON_AUTO_REPEAT_EN
  localparam int unsigned HCNT_W = $clog2(max_u(max_u(REPEAT_DELAY, REPEAT_PERIOD), 2));
  localparam logic [HCNT_W-1:0] DELAY_MAX  = HCNT_W'(REPEAT_DELAY - 1);
  localparam logic [HCNT_W-1:0] PERIOD_MAX = HCNT_W'(REPEAT_PERIOD - 1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              rep_q, rep_d;   // set once the first repeat has fired
`endif

  btn_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn.btn_raw),
    .q     (s)
  );

  // State, counters and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
`ifdef STEP_BUTTON_AUTO_REPEAT_EN
      hcnt_q  <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
`ifdef STEP_BUTTON_AUTO_REPEAT_EN
      hcnt_q  <= hcnt_d;
      rep_q   <= rep_d;
`endif
    end
  end

  // Next-state and next-output logic; step_pulse defaults low so it lasts one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
`ifdef STEP_BUTTON_AUTO_REPEAT_EN
    hcnt_d  = hcnt_q;
    rep_d   = rep_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
`ifdef STEP_BUTTON_AUTO_REPEAT_EN
          hcnt_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
`ifdef STEP_BUTTON_AUTO_REPEAT_EN
          // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD
          if (hcnt_q == (rep_q ? PERIOD_MAX : DELAY_MAX)) begin
            pulse_d = 1'b1;
            hcnt_d  = '0;
            rep_d   = 1'b1;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
`endif
        end
      end

      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn.step_pulse = pulse_q;
  assign btn.btn_level  = level_q;

endmodule

// File: tb/tb_step_button_debounce.sv
// Directed self-checking bench for step_button_debounce (SYNC=2, DEBOUNCE=4).
module tb_step_button_debounce;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  step_button_debounce_if bif ();

  step_button_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present v for the next rising edge, then settle just after it
  task automatic step(input logic v);
    bif.btn_raw = v;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 12; i++) step(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bif.btn_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bif.step_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_pulse got %b want 0", bif.step_pulse);
    end
    n_cmp++;
    if (bif.btn_level !== 1'b0) begin
      n_err++; $display("FAIL reset_level got %b want 0", bif.btn_level);
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b1);
      n_cmp++;
      if (bif.step_pulse !== 1'b0 || bif.btn_level !== 1'b0) begin
        n_err++; $display("FAIL reset_held cycle %0d got pulse=%b level=%b want 0/0",
                          k, bif.step_pulse, bif.btn_level);
      end
    end
    bif.btn_raw = 1'b0;
    reset = 1'b1;
    go_idle();
  endtask

  task automatic test_clean_press();
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      n_cmp++;
      if (bif.step_pulse !== (k == 7)) begin
        n_err++; $display("FAIL clean_press_pulse edge %0d got %b want %b", k, bif.step_pulse, (k == 7));
      end
      n_cmp++;
      if (bif.btn_level !== (k >= 7)) begin
        n_err++; $display("FAIL clean_press_level edge %0d got %b want %b", k, bif.btn_level, (k >= 7));
      end
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      n_cmp++;
      if (bif.step_pulse !== 1'b0 || bif.btn_level !== (k < 7)) begin
        n_err++; $display("FAIL clean_release edge %0d got pulse=%b level=%b want 0/%b",
                          k, bif.step_pulse, bif.btn_level, (k < 7));
      end
    end
    go_idle();
  endtask

  task automatic test_bouncy_press();
    logic [3:0] bounce;
    bounce = 4'b0101;  // edges 1..4 sample 1,0,1,0
    for (int k = 1; k <= 14; k++) begin
      step((k <= 4) ? bounce[k-1] : 1'b1);
      n_cmp++;
      if (bif.step_pulse !== (k == 11)) begin
        n_err++; $display("FAIL bouncy_pulse edge %0d got %b want %b", k, bif.step_pulse, (k == 11));
      end
      n_cmp++;
      if (bif.btn_level !== (k >= 11)) begin
        n_err++; $display("FAIL bouncy_level edge %0d got %b want %b", k, bif.btn_level, (k >= 11));
      end
    end
    go_idle();
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 13; k++) begin
      step((k <= 3) ? 1'b1 : 1'b0);
      n_cmp++;
      if (bif.step_pulse !== 1'b0 || bif.btn_level !== 1'b0) begin
        n_err++; $display("FAIL glitch edge %0d got pulse=%b level=%b want 0/0",
                          k, bif.step_pulse, bif.btn_level);
      end
    end
    go_idle();
  endtask

  task automatic test_release_bounce();
    for (int k = 1; k <= 9; k++) step(1'b1);
    n_cmp++;
    if (bif.btn_level !== 1'b1) begin
      n_err++; $display("FAIL rb_pressed_level got %b want 1", bif.btn_level);
    end
    // release samples 0,0,1,1 then 0 from edge 5 on
    for (int k = 1; k <= 14; k++) begin
      step((k == 3 || k == 4) ? 1'b1 : 1'b0);
      n_cmp++;
      if (bif.step_pulse !== 1'b0) begin
        n_err++; $display("FAIL rb_pulse edge %0d got %b want 0", k, bif.step_pulse);
      end
      n_cmp++;
      if (bif.btn_level !== (k < 11)) begin
        n_err++; $display("FAIL rb_level edge %0d got %b want %b", k, bif.btn_level, (k < 11));
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 4; k++) step(1'b1);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bif.step_pulse !== 1'b0 || bif.btn_level !== 1'b0) begin
      n_err++; $display("FAIL rst_pw_outputs got pulse=%b level=%b want 0/0", bif.step_pulse, bif.btn_level);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1'b1);
      n_cmp++;
      if (bif.step_pulse !== (k == 7)) begin
        n_err++; $display("FAIL rst_requal_pulse edge %0d got %b want %b", k, bif.step_pulse, (k == 7));
      end
    end
    // pulse in flight is dropped at once
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bif.step_pulse !== 1'b0 || bif.btn_level !== 1'b0) begin
      n_err++; $display("FAIL rst_inflight got pulse=%b level=%b want 0/0", bif.step_pulse, bif.btn_level);
    end
    bif.btn_raw = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    go_idle();
  endtask

  task automatic test_hold();
    logic exp;
    for (int k = 1; k <= 52; k++) begin
      step((k <= 40) ? 1'b1 : 1'b0);
`ifdef STEP_BUTTON_AUTO_REPEAT_EN
      exp = (k == 7) || (k >= 17 && k <= 42 && ((k - 17) % 5) == 0);
`else
      exp = (k == 7);
`endif
      n_cmp++;
      if (bif.step_pulse !== exp) begin
        n_err++; $display("FAIL hold_pulse edge %0d got %b want %b", k, bif.step_pulse, exp);
      end
      n_cmp++;
      if (bif.btn_level !== (k >= 7 && k < 47)) begin
        n_err++; $display("FAIL hold_level edge %0d got %b want %b", k, bif.btn_level, (k >= 7 && k < 47));
      end
    end
    go_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bif.btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_glitch();
    test_release_bounce();
    test_reset_mid();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_button_debounce.md
# step_button_debounce

Conditions the raw push-button that advances the mod-12 counter on the FPGA board. It synchronises the asynchronous pad, debounces it with a counter-based state machine and emits a single-cycle `step_pulse` that drives the counter's clock-enable/step input one stage downstream. `btn_level` exposes the clean, debounced button level for status LEDs.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `btn_raw`; minimum 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, 25000000: held cycles before the first auto-repeat pulse. Used only with `AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, 10000000: cycles between later auto-repeat pulses. Used only with `AUTO_REPEAT_EN`.
- `clk`, input, 1: single system clock; all logic on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Assertion is immediate; release is synchronous to `clk` at board level.
- `btn_raw`, input, 1: raw button pad, active-high, asynchronous and bouncing.
- `step_pulse`, output, 1: registered, high for exactly one cycle per accepted press (and per repeat).
- `btn_level`, output, 1: registered, debounced button level.

## Operation
- Reset values while `reset` is low:
  - all synchroniser flops 0;
  - state IDLE;
  - counters 0;
  - `step_pulse` = 0;
  - `btn_level` = 0.
- `s` is the output of the last synchroniser stage. The FSM uses only `s`.
- `cnt` is the debounce counter, width `$clog2(DEBOUNCE_CYCLES)`. It never wraps; it is cleared on every state entry.
- IDLE:
  - `s`=1 → PRESS_WAIT, `cnt`=0.
- PRESS_WAIT:
  - `s`=0 → IDLE (bounce rejected, no pulse).
  - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED. Set `btn_level`=1 and `step_pulse`=1 on that edge.
  - Otherwise `cnt`++.
- PRESSED:
  - `s`=0 → RELEASE_WAIT, `cnt`=0.
  - `step_pulse` is forced back to 0 on the following edge.
- RELEASE_WAIT:
  - `s`=1 → PRESSED (bounce on release). No pulse; `btn_level` stays 1.
  - `s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE, `btn_level`=0.
  - Otherwise `cnt`++.
- `step_pulse` is asserted only on the PRESS_WAIT→PRESSED transition, plus auto-repeat when enabled. A release never produces a pulse.
- Reset asserted in any state returns immediately to the reset values. A pulse in flight is dropped.
- If the button is held through reset release, the module re-qualifies the press and generates one fresh pulse after the full latency.

## Timing
- Edge 1 is the first rising edge that samples `btn_raw`=1 after a stable low.
- If the input then stays high, `step_pulse` is high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 and low again after the next edge.
- `btn_level` rises on the same edge as `step_pulse`.
- Release latency is the same: `btn_level` falls after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1, counted from the first edge sampling `btn_raw`=0.
- Any change of `s` during a WAIT state restarts qualification as defined in Operation. A pulse therefore requires `DEBOUNCE_CYCLES` uninterrupted high samples.
- Minimum spacing of two non-repeat pulses is 2×`DEBOUNCE_CYCLES`+2 cycles.

## Configuration
- `STEP_BUTTON_AUTO_REPEAT_EN` defined:
  - PRESSED keeps a hold counter `hcnt`, cleared on PRESSED entry from PRESS_WAIT.
  - When `hcnt` reaches `REPEAT_DELAY`-1, it emits a one-cycle `step_pulse` and reloads.
  - It then pulses every `REPEAT_PERIOD` cycles while in PRESSED.
  - Entry to PRESSED from RELEASE_WAIT (release bounce) does not clear `hcnt` and does not emit a pulse.
- Not defined: `hcnt` and the repeat logic are absent. Exactly one pulse per press.

## Structure
- Package `step_button_pkg`:
  - state typedef `btn_state_t` {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - default timing constants for the 50 MHz board clock.
- Sub-module `btn_synchronizer`: a `SYNC_STAGES`-deep flop chain on `clk` with active-low async reset to 0.
- The FSM, counters and output registers live in the top module.

## Test plan
Use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- Clean press: `btn_raw` rises and is held.
  - `step_pulse` is high only after edge 7; `btn_level`=1 from edge 7.
- Bouncy press: `btn_raw` toggles 1,0,1,0 on four consecutive cycles, then held high.
  - No pulse during the toggling; exactly one pulse, 7 edges after the final rise.
- Glitch: `btn_raw` high for 3 cycles, then low.
  - `step_pulse` and `btn_level` stay 0 throughout.
- Release with a 2-cycle high bounce mid-release.
  - `btn_level` stays 1 and no pulse occurs.
  - `btn_level` falls 7 edges after the final fall.
- Reset asserted low during PRESS_WAIT, then released with the button held.
  - Outputs 0 immediately; one pulse 7 edges after the first post-reset sample.
- Auto-repeat (macro defined), button held for 40 cycles.
  - Pulses at edges 7, 17, 22, 27, 32, 37, 42 (only those within the hold window).
  - Macro undefined: a single pulse at edge 7.
